sprite_line_scanner: RTL and testbench



---
 rtl/console_pkg.sv | 22 ++
 rtl/sprite_span_check.sv | 21 ++
 rtl/sprite_line_scanner.sv | 154 +++++++++++++++
 tb/tb_sprite_line_scanner.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/console_pkg.sv
// Shared widths, scan FSM encoding and the sprite table entry used by the line scanner.
package console_pkg;

  localparam int COORD_X_W   = 11;
  localparam int COORD_Y_W   = 10;
  localparam int NUM_SPRITES = 4;
  localparam int SEL_W       = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    COMMIT = 2'd3
  } scan_state_t;

  typedef struct packed {
    logic [COORD_X_W-1:0] x;
    logic [5:0]           off_y;
    logic                 valid;
  } sprite_entry_t;

endpackage

// File: rtl/sprite_span_check.sv
// Horizontal coverage test of one committed sprite against the current pixel column.
module sprite_span_check
  import console_pkg::*;
#(
  parameter int SPRITE_W = 20
) (
  input  logic [COORD_X_W-1:0] pixel_x,
  input  logic [COORD_X_W-1:0] x_i,
  input  logic                 valid_i,
  output logic                 in_span,
  output logic [5:0]           offset
);

  logic [COORD_X_W:0] x_end;

  // One extra bit keeps sprites near the right edge from wrapping to column 0.
  assign x_end   = {1'b0, x_i} + (COORD_X_W+1)'(SPRITE_W);
  assign in_span = valid_i && (pixel_x >= x_i) && ({1'b0, pixel_x} < x_end);
  assign offset  = pixel_x[5:0] - x_i[5:0];

endmodule

// File: rtl/sprite_line_scanner.sv
// Per-line sprite scan: walks the coordinate mux selector, builds a line table, and reports pixel hits.
module sprite_line_scanner
  import console_pkg::*;
#(
  parameter int SPRITE_W = 20,
  parameter int SPRITE_H = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 new_line,
  input  logic [COORD_Y_W-1:0] line_y,
  input  logic [COORD_X_W-1:0] pixel_x,
  input  logic                 pixel_valid,
  input  logic [COORD_X_W-1:0] mux_x,
  input  logic [COORD_Y_W-1:0] mux_y,
  output logic [SEL_W-1:0]     selector,
  output logic                 scan_busy,
  output logic                 scan_done,
  output logic [NUM_SPRITES-1:0] active_mask,
  output logic                 hit,
  output logic [SEL_W-1:0]     hit_id,
  output logic [5:0]           hit_off_x,
  output logic [5:0]           hit_off_y
);

  scan_state_t     state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;

  sprite_entry_t shadow    [NUM_SPRITES];
  sprite_entry_t committed [NUM_SPRITES];

  logic [COORD_Y_W:0] y_end;
  logic               sample_valid;
  logic [5:0]         sample_off_y;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (new_line) begin
          idx_d   = '0;
          state_d = SETTLE;
        end
      end
      SETTLE: state_d = SAMPLE;
      SAMPLE: begin
        if (idx_q == SEL_W'(NUM_SPRITES-1)) begin
          state_d = COMMIT;
        end else begin
          idx_d   = idx_q + SEL_W'(1);
          state_d = SETTLE;
        end
      end
      COMMIT: begin
        idx_d   = '0;
        state_d = IDLE;
      end
      default: begin
        idx_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign selector  = idx_q;
  assign scan_busy = (state_q != IDLE);
  assign scan_done = (state_q == COMMIT);

  assign y_end        = {1'b0, mux_y} + (COORD_Y_W+1)'(SPRITE_H);
  assign sample_valid = (line_y >= mux_y) && ({1'b0, line_y} < y_end);
  assign sample_off_y = line_y[5:0] - mux_y[5:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
        shadow[i]    <= '0;
        committed[i] <= '0;
      end
    end else begin
      if (state_q == SAMPLE) begin
        shadow[idx_q] <= '{x: mux_x, off_y: sample_off_y, valid: sample_valid};
      end
      if (state_q == COMMIT) begin
        for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
          committed[i] <= shadow[i];
        end
      end
    end
  end

  logic [NUM_SPRITES-1:0] in_span;
  logic [5:0]             span_off [NUM_SPRITES];

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_span
    assign active_mask[g] = committed[g].valid;

    sprite_span_check #(
      .SPRITE_W (SPRITE_W)
    ) u_span (
      .pixel_x (pixel_x),
      .x_i     (committed[g].x),
      .valid_i (committed[g].valid),
      .in_span (in_span[g]),
      .offset  (span_off[g])
    );
  end

  logic             hit_d;
  logic [SEL_W-1:0] hit_id_d;
  logic [5:0]       hit_off_x_d;
  logic [5:0]       hit_off_y_d;

  // Ascending scan that latches only the first match gives lowest-index priority.
  always_comb begin
    hit_d       = 1'b0;
    hit_id_d    = '0;
    hit_off_x_d = '0;
    hit_off_y_d = '0;
    for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
      if (!hit_d && pixel_valid && in_span[i]) begin
        hit_d       = 1'b1;
        hit_id_d    = SEL_W'(i);
        hit_off_x_d = span_off[i];
        hit_off_y_d = committed[i].off_y;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hit       <= 1'b0;
      hit_id    <= '0;
      hit_off_x <= '0;
      hit_off_y <= '0;
    end else begin
      hit       <= hit_d;
      hit_id    <= hit_id_d;
      hit_off_x <= hit_off_x_d;
      hit_off_y <= hit_off_y_d;
    end
  end

endmodule

// File: tb/tb_sprite_line_scanner.sv
// Directed bench for sprite_line_scanner with a behavioural 4-way coordinate multiplexer.
module tb_sprite_line_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic        new_line;
  logic [9:0]  line_y;
  logic [10:0] pixel_x;
  logic        pixel_valid;
  logic [10:0] mux_x;
  logic [9:0]  mux_y;
  logic [1:0]  selector;
  logic        scan_busy;
  logic        scan_done;
  logic [3:0]  active_mask;
  logic        hit;
  logic [1:0]  hit_id;
  logic [5:0]  hit_off_x;
  logic [5:0]  hit_off_y;

  logic [10:0] spr_x [4];
  logic [9:0]  spr_y [4];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int done_base;

  always #5 clk = ~clk;

  assign mux_x = spr_x[selector];
  assign mux_y = spr_y[selector];

  always @(posedge clk) if (scan_done === 1'b1) done_cnt++;

  sprite_line_scanner #(
    .SPRITE_W (20),
    .SPRITE_H (20)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .new_line    (new_line),
    .line_y      (line_y),
    .pixel_x     (pixel_x),
    .pixel_valid (pixel_valid),
    .mux_x       (mux_x),
    .mux_y       (mux_y),
    .selector    (selector),
    .scan_busy   (scan_busy),
    .scan_done   (scan_done),
    .active_mask (active_mask),
    .hit         (hit),
    .hit_id      (hit_id),
    .hit_off_x   (hit_off_x),
    .hit_off_y   (hit_off_y)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_sprites(input logic [10:0] x0, x1, x2, x3, input logic [9:0] y0, y1, y2, y3);
    spr_x[0] = x0; spr_x[1] = x1; spr_x[2] = x2; spr_x[3] = x3;
    spr_y[0] = y0; spr_y[1] = y1; spr_y[2] = y2; spr_y[3] = y3;
  endtask

  // Called at a negedge; rp selects a scan cycle at which new_line is pulsed again (-1: never).
  task automatic run_scan(input logic [9:0] ly, input int rp);
    line_y   = ly;
    new_line = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      new_line = (k == rp);
      check("scan_selector", {30'd0, selector}, k / 2);
      check("scan_busy", {31'd0, scan_busy}, 1);
      check("scan_done_early", {31'd0, scan_done}, 0);
      @(negedge clk);
    end
    new_line = 1'b0;
    check("scan_done_pulse", {31'd0, scan_done}, 1);
    @(negedge clk);
    check("scan_done_clear", {31'd0, scan_done}, 0);
    check("scan_busy_clear", {31'd0, scan_busy}, 0);
  endtask

  task automatic pix(input string tag, input logic [10:0] x, input logic v,
                     input logic eh, input logic [1:0] eid, input logic [5:0] eox, input logic [5:0] eoy);
    pixel_x     = x;
    pixel_valid = v;
    @(negedge clk);
    check({tag, "_hit"}, {31'd0, hit}, {31'd0, eh});
    check({tag, "_id"}, {30'd0, hit_id}, {30'd0, eid});
    check({tag, "_offx"}, {26'd0, hit_off_x}, {26'd0, eox});
    check({tag, "_offy"}, {26'd0, hit_off_y}, {26'd0, eoy});
    pixel_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; new_line = 1'b0; line_y = '0; pixel_x = '0; pixel_valid = 1'b0;
    set_sprites(11'd300, 11'd400, 11'd500, 11'd600, 10'd90, 10'd100, 10'd130, 10'd0);
    repeat (3) @(negedge clk);
    check("rst_selector", {30'd0, selector}, 0);
    check("rst_busy", {31'd0, scan_busy}, 0);
    check("rst_done", {31'd0, scan_done}, 0);
    check("rst_mask", {28'd0, active_mask}, 0);
    check("rst_hit", {31'd0, hit}, 0);
    reset = 1'b0;
    @(negedge clk);

    // Basic line: sprites 0 and 1 intersect line 100.
    run_scan(10'd100, -1);
    check("basic_mask", {28'd0, active_mask}, 4'b0011);
    pix("basic_s0", 11'd305, 1'b1, 1'b1, 2'd0, 6'd5, 6'd10);
    pix("basic_s1", 11'd405, 1'b1, 1'b1, 2'd1, 6'd5, 6'd0);
    pix("basic_s2off", 11'd505, 1'b1, 1'b0, 2'd0, 6'd0, 6'd0);

    // Vertical boundaries of sprite 0 at y=50.
    set_sprites(11'd300, 11'd400, 11'd500, 11'd600, 10'd50, 10'd1023, 10'd1023, 10'd1023);
    run_scan(10'd69, -1);
    check("row69_mask", {28'd0, active_mask}, 4'b0001);
    pix("row69_left", 11'd300, 1'b1, 1'b1, 2'd0, 6'd0, 6'd19);
    pix("row69_right", 11'd319, 1'b1, 1'b1, 2'd0, 6'd19, 6'd19);
    pix("row69_past", 11'd320, 1'b1, 1'b0, 2'd0, 6'd0, 6'd0);
    run_scan(10'd70, -1);
    check("row70_mask", {28'd0, active_mask}, 4'b0000);
    run_scan(10'd49, -1);
    check("row49_mask", {28'd0, active_mask}, 4'b0000);

    // Overlap priority between sprites 1 and 2.
    set_sprites(11'd0, 11'd200, 11'd210, 11'd0, 10'd1023, 10'd100, 10'd100, 10'd1023);
    run_scan(10'd100, -1);
    check("ovl_mask", {28'd0, active_mask}, 4'b0110);
    pix("ovl_215", 11'd215, 1'b1, 1'b1, 2'd1, 6'd15, 6'd0);
    pix("ovl_225", 11'd225, 1'b1, 1'b1, 2'd2, 6'd15, 6'd0);
    pix("ovl_novalid", 11'd215, 1'b0, 1'b0, 2'd0, 6'd0, 6'd0);

    // Right screen edge: no wrap to low columns.
    set_sprites(11'd2040, 11'd0, 11'd0, 11'd0, 10'd100, 10'd1023, 10'd1023, 10'd1023);
    run_scan(10'd105, -1);
    check("edge_mask", {28'd0, active_mask}, 4'b0001);
    pix("edge_2039", 11'd2039, 1'b1, 1'b0, 2'd0, 6'd0, 6'd0);
    pix("edge_2047", 11'd2047, 1'b1, 1'b1, 2'd0, 6'd7, 6'd5);
    pix("edge_nowrap", 11'd5, 1'b1, 1'b0, 2'd0, 6'd0, 6'd0);

    // new_line re-pulsed mid-scan is ignored.
    done_base = done_cnt;
    run_scan(10'd105, 3);
    repeat (3) @(negedge clk);
    check("repulse_done_cnt", done_cnt - done_base, 1);
    check("repulse_idle", {31'd0, scan_busy}, 0);

    // Reset during scan cycle 5 aborts and clears the committed table.
    line_y   = 10'd100;
    new_line = 1'b1;
    @(negedge clk);
    new_line = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_selector", {30'd0, selector}, 0);
    check("abort_busy", {31'd0, scan_busy}, 0);
    check("abort_mask", {28'd0, active_mask}, 0);
    reset = 1'b0;
    @(negedge clk);
    run_scan(10'd100, -1);
    check("fresh_mask", {28'd0, active_mask}, 4'b0001);
    pix("fresh_hit", 11'd2045, 1'b1, 1'b1, 2'd0, 6'd5, 6'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
